// File: rtl/csr_file.sv
// Machine-mode CSR register file for the RV32I core.
// Combinational reads, edge-committed writes, 64-bit counters, trap/MRET state.
module csr_file #(
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] csr_addr,
    input  logic        csr_read_enable,
    input  logic        csr_write_enable,
    input  logic [31:0] csr_write_data,
    output logic [31:0] csr_read_data,
    output logic        csr_valid,
    input  logic        instr_retired,
    input  logic        trap_enter,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_val,
    input  logic        mret,
    input  logic        ext_irq,
    input  logic        timer_irq,
    input  logic        sw_irq,
    output logic [31:0] mtvec_out,
    output logic [31:0] mepc_out,
    output logic        mie_global
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;
    localparam logic [11:0] A_MVENDORID = 12'hF11;
    localparam logic [11:0] A_MARCHID   = 12'hF12;
    localparam logic [11:0] A_MIMPID    = 12'hF13;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    localparam logic [31:0] MISA_VALUE  = 32'h4000_0100;

    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic        mie_meie;
    logic        mie_mtie;
    logic        mie_msie;
    logic [31:0] mtvec_q;
    logic [31:0] mscratch_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [31:0] mtval_q;
    logic [63:0] mcycle_q;
    logic [63:0] minstret_q;

    logic [31:0] mstatus_rd;
    logic [31:0] mie_rd;
    logic [31:0] mip_rd;

    logic        addr_hit;
    logic        addr_writable;
    logic [31:0] rdata;
    logic        wr_en;

    logic        wr_mstatus;
    logic        wr_mie;
    logic        wr_mtvec;
    logic        wr_mscratch;
    logic        wr_mepc;
    logic        wr_mcause;
    logic        wr_mtval;
    logic        wr_mcycle_lo;
    logic        wr_mcycle_hi;
    logic        wr_minstret_lo;
    logic        wr_minstret_hi;

    // MPP is hardwired to M-mode; only MIE and MPIE hold state
    assign mstatus_rd = {19'd0, 2'b11, 3'd0, mstatus_mpie,
                         3'd0, mstatus_mie, 3'd0};
    assign mie_rd     = {20'd0, mie_meie, 3'd0, mie_mtie,
                         3'd0, mie_msie, 3'd0};
    assign mip_rd     = {20'd0, ext_irq, 3'd0, timer_irq,
                         3'd0, sw_irq, 3'd0};

    // Address decode: implemented flag, writability and read mux
    always_comb begin
        addr_hit      = 1'b1;
        addr_writable = 1'b0;
        rdata         = 32'd0;
        unique case (csr_addr)
            A_MSTATUS: begin
                rdata         = mstatus_rd;
                addr_writable = 1'b1;
            end
            A_MISA:     rdata = MISA_VALUE;
            A_MIE: begin
                rdata         = mie_rd;
                addr_writable = 1'b1;
            end
            A_MTVEC: begin
                rdata         = mtvec_q;
                addr_writable = 1'b1;
            end
            A_MSCRATCH: begin
                rdata         = mscratch_q;
                addr_writable = 1'b1;
            end
            A_MEPC: begin
                rdata         = mepc_q;
                addr_writable = 1'b1;
            end
            A_MCAUSE: begin
                rdata         = mcause_q;
                addr_writable = 1'b1;
            end
            A_MTVAL: begin
                rdata         = mtval_q;
                addr_writable = 1'b1;
            end
            A_MIP:      rdata = mip_rd;
            A_MCYCLE: begin
                rdata         = mcycle_q[31:0];
                addr_writable = 1'b1;
            end
            A_MINSTRET: begin
                rdata         = minstret_q[31:0];
                addr_writable = 1'b1;
            end
            A_MCYCLEH: begin
                rdata         = mcycle_q[63:32];
                addr_writable = 1'b1;
            end
            A_MINSTRETH: begin
                rdata         = minstret_q[63:32];
                addr_writable = 1'b1;
            end
            A_CYCLE:     rdata = mcycle_q[31:0];
            A_INSTRET:   rdata = minstret_q[31:0];
            A_CYCLEH:    rdata = mcycle_q[63:32];
            A_INSTRETH:  rdata = minstret_q[63:32];
            A_MVENDORID: rdata = 32'd0;
            A_MARCHID:   rdata = 32'd0;
            A_MIMPID:    rdata = 32'd0;
            A_MHARTID:   rdata = HART_ID;
            default: begin
                addr_hit = 1'b0;
                rdata    = 32'd0;
            end
        endcase
    end

    assign csr_valid     = csr_read_enable & addr_hit;
    assign csr_read_data = rdata;
    assign wr_en         = csr_write_enable & csr_valid & addr_writable;

    // Per-register write strobes
    always_comb begin
        wr_mstatus     = wr_en && (csr_addr == A_MSTATUS);
        wr_mie         = wr_en && (csr_addr == A_MIE);
        wr_mtvec       = wr_en && (csr_addr == A_MTVEC);
        wr_mscratch    = wr_en && (csr_addr == A_MSCRATCH);
        wr_mepc        = wr_en && (csr_addr == A_MEPC);
        wr_mcause      = wr_en && (csr_addr == A_MCAUSE);
        wr_mtval       = wr_en && (csr_addr == A_MTVAL);
        wr_mcycle_lo   = wr_en && (csr_addr == A_MCYCLE);
        wr_mcycle_hi   = wr_en && (csr_addr == A_MCYCLEH);
        wr_minstret_lo = wr_en && (csr_addr == A_MINSTRET);
        wr_minstret_hi = wr_en && (csr_addr == A_MINSTRETH);
    end

    // mstatus interrupt-enable stack: trap beats mret beats CSR write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
        end else if (trap_enter) begin
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
        end else if (mret) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
        end else if (wr_mstatus) begin
            mstatus_mie  <= csr_write_data[3];
            mstatus_mpie <= csr_write_data[7];
        end
    end

    // Interrupt enables: only MEIE/MTIE/MSIE exist
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie_meie <= 1'b0;
            mie_mtie <= 1'b0;
            mie_msie <= 1'b0;
        end else if (wr_mie) begin
            mie_meie <= csr_write_data[11];
            mie_mtie <= csr_write_data[7];
            mie_msie <= csr_write_data[3];
        end
    end

    // Trap vector: reserved MODE encodings collapse to direct mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtvec_q <= MTVEC_RESET;
        end else if (wr_mtvec) begin
            mtvec_q <= {csr_write_data[31:2], 1'b0,
                        csr_write_data[1:0] == 2'b01};
        end
    end

    // Scratch register, untouched by traps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mscratch_q <= 32'd0;
        end else if (wr_mscratch) begin
            mscratch_q <= csr_write_data;
        end
    end

    // Trap capture registers: trap entry overrides software writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mepc_q   <= 32'd0;
            mcause_q <= 32'd0;
            mtval_q  <= 32'd0;
        end else if (trap_enter) begin
            mepc_q   <= {trap_pc[31:2], 2'b00};
            mcause_q <= trap_cause;
            mtval_q  <= trap_val;
        end else begin
            if (wr_mepc) begin
                mepc_q <= {csr_write_data[31:2], 2'b00};
            end
            if (wr_mcause) begin
                mcause_q <= csr_write_data;
            end
            if (wr_mtval) begin
                mtval_q <= csr_write_data;
            end
        end
    end

    // Cycle counter: a write to either half replaces it and skips the tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcycle_q <= 64'd0;
        end else if (wr_mcycle_lo) begin
            mcycle_q[31:0] <= csr_write_data;
        end else if (wr_mcycle_hi) begin
            mcycle_q[63:32] <= csr_write_data;
        end else begin
            mcycle_q <= mcycle_q + 64'd1;
        end
    end

    // Retired-instruction counter, same write/skip rule as mcycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            minstret_q <= 64'd0;
        end else if (wr_minstret_lo) begin
            minstret_q[31:0] <= csr_write_data;
        end else if (wr_minstret_hi) begin
            minstret_q[63:32] <= csr_write_data;
        end else if (instr_retired) begin
            minstret_q <= minstret_q + 64'd1;
        end
    end

    assign mtvec_out  = mtvec_q;
    assign mepc_out   = mepc_q;
    assign mie_global = mstatus_mie;

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode CSR register file; the responder end of the execution unit's CSR interface.
- Reads: combinational address decode; returns data and a valid flag in the same cycle.
- Writes: committed on the clock edge.
- Also owns the 64-bit cycle/instret counters and trap-entry/MRET state updates, and exports mtvec/mepc/MIE to the fetch and trap logic.

Parameters:
- HART_ID, 0, value returned by mhartid.
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- csr_addr  in  12  CSR address (imm[11:0] of the CSR instruction)
- csr_read_enable  in  1  CSR instruction present in EX
- csr_write_enable  in  1  write request from csr_exec
- csr_write_data  in  32  fully computed new value (RW/RS/RC already resolved upstream)
- csr_read_data  out  32  current CSR value, combinational
- csr_valid  out  1  address implemented, combinational
- instr_retired  in  1  one instruction retired this cycle
- trap_enter  in  1  take a trap this cycle
- trap_pc  in  32  PC of the trapping instruction
- trap_cause  in  32  mcause value
- trap_val  in  32  mtval value
- mret  in  1  MRET executing
- ext_irq, timer_irq, sw_irq  in  1 each  raw interrupt lines (mip MEIP/MTIP/MSIP)
- mtvec_out  out  32  mtvec register
- mepc_out  out  32  mepc register
- mie_global  out  1  mstatus.MIE

Behaviour:
- Reset (async): every register 0 except mtvec=MTVEC_RESET and mstatus.MPP=2'b11. Outputs follow immediately.
- Implemented addresses:
  - mstatus 300, misa 301, mie 304, mtvec 305, mscratch 340, mepc 341, mcause 342, mtval 343, mip 344.
  - mcycle B00, minstret B02, mcycleh B80, minstreth B82.
  - cycle C00, instret C02, cycleh C80, instreth C82 (read-only aliases).
  - mvendorid F11, marchid F12, mimpid F13 (read 0); mhartid F14 (reads HART_ID).
- csr_valid = csr_read_enable AND address implemented. Unimplemented address: csr_valid=0, csr_read_data=0, write ignored.
- csr_read_data reflects register state before the current edge. No same-cycle write bypass.
- Writes:
  - Occur at posedge when csr_write_enable AND csr_valid AND the address is writable.
  - Writes to misa, mip, Cxx aliases and Fxx addresses are silently dropped; csr_valid stays 1.
- WARL field rules:
  - mstatus: only MIE[3] and MPIE[7] are writable; MPP[12:11] reads 2'b11; all other bits read 0.
  - mie: only bits 11, 7, 3 are writable.
  - mtvec: bits [31:2] writable. MODE[1:0] accepts 00/01; a written 10 or 11 stores 00.
  - mepc: bits [1:0] forced to 0 on write and on trap.
- mip is read-only: bit11=ext_irq, bit7=timer_irq, bit3=sw_irq, sampled combinationally.
- misa reads 32'h4000_0100 (RV32I).
- Counters (64-bit):
  - mcycle increments every cycle after reset. minstret increments when instr_retired=1. Both wrap from 2^64-1 to 0.
  - A CSR write to either half of a counter replaces that half, holds the other half, and suppresses that counter's increment for that cycle.
- Trap entry (trap_enter=1), at posedge:
  - mepc=trap_pc&~3, mcause=trap_cause, mtval=trap_val, MPIE=MIE, MIE=0.
- mret=1 (no trap), at posedge: MIE=MPIE, MPIE=1.
- Priority within one cycle: trap_enter > mret > CSR write, per affected register. A CSR write to a register a trap/mret does not touch (e.g. mscratch) still commits.
- csr_write_enable without csr_read_enable: csr_valid=0, so no write occurs.

Test Plan:
- Reset check → read mtvec (305) returns MTVEC_RESET; read mstatus (300) returns 32'h0000_1800; mie_global=0.
- Write mscratch (340) with 32'hDEAD_BEEF → same cycle reads old value 0; next cycle reads DEADBEEF. Then write misa with 32'hFFFF_FFFF → misa still reads 40000100 and csr_valid=1.
- Read address 7C0 → csr_valid=0, data 0. Write mtvec 32'h0000_1003 → reads 32'h0000_1000.
- After reset, hold instr_retired=1 for 5 cycles → minstret=5, mcycle ≥ 5.
  - Write mcycle=FFFF_FFFF, mcycleh=0 on consecutive cycles → next cycle mcycleh=1, mcycle=0.
  - Assert rst mid-count → counters read 0 immediately.
- Set MIE=1 via mstatus write 8; then trap_enter with trap_pc=32'h0000_0102, cause=11, val=0 → mepc=32'h0000_0100, mcause=11, mstatus=32'h0000_1880, mie_global=0. Then mret → mstatus=32'h0000_1888.
- Same cycle: trap_enter + mret + CSR write of mepc=32'h0000_0200 → mepc=trap_pc&~3 and the MRET effect is absent. Separately, trap + mscratch write in the same cycle → both commit.
